// File: rtl/fft_pkg.sv
// Shared FFT constants (magnitude width, result address width, frame length) and the capture FSM state type.
package fft_pkg;
  localparam int FFT_MAG_WIDTH  = 26;
  localparam int FFT_ADDR_WIDTH = 13;
  localparam int FFT_FRAME_LEN  = 8192;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_CAPTURE = 2'd1,
    CAP_DONE    = 2'd2
  } cap_state_e;
endpackage

// File: rtl/fft_result_ram.sv
// Simple dual-port result RAM: one write port plus a registered, read-first read port.
// The array has no reset; only the read register clears, so captured data survives reset.
module fft_result_ram
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_MAG_WIDTH,
  parameter int ADDR_WIDTH = FFT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Non-blocking read of the same array gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/fft_result_capture.sv
// Captures one streamed FFT magnitude frame into RAM; s_ready is decoded from state, one beat per cycle.
// Frame ends on s_last or FRAME_LEN beats; rd_data follows rd_addr by one cycle like the result ROM.
module fft_result_capture
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_MAG_WIDTH,
  parameter int ADDR_WIDTH = FFT_ADDR_WIDTH,
  parameter int FRAME_LEN  = FFT_FRAME_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [ADDR_WIDTH:0]   captured_count
);
  localparam logic [ADDR_WIDTH:0] FRAME_LEN_C = (ADDR_WIDTH+1)'(FRAME_LEN);

  cap_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    done_q, done_d;
  logic                    len_err_q, len_err_d;
  logic                    accept;
  logic [ADDR_WIDTH:0]     count_inc;
  logic                    hit_len;

  assign accept    = (state_q == CAP_CAPTURE) && s_valid;
  assign count_inc = count_q + 1'b1;
  assign hit_len   = (count_inc == FRAME_LEN_C);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    done_d    = done_q;
    len_err_d = len_err_q;
    case (state_q)
      CAP_IDLE, CAP_DONE: begin
        if (arm) begin
          state_d   = CAP_CAPTURE;
          wr_ptr_d  = '0;
          count_d   = '0;
          done_d    = 1'b0;
          len_err_d = 1'b0;
        end
      end
      CAP_CAPTURE: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_inc;
          // Only s_last landing exactly on the expected beat count is a clean frame.
          if (s_last || hit_len) begin
            state_d   = CAP_DONE;
            done_d    = 1'b1;
            len_err_d = !(s_last && hit_len);
          end
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CAP_IDLE;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  assign s_ready        = (state_q == CAP_CAPTURE);
  assign busy           = (state_q == CAP_CAPTURE);
  assign done           = done_q;
  assign len_err        = len_err_q;
  assign captured_count = count_q;

  fft_result_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (accept && !rst),
    .wr_addr(wr_ptr_q),
    .wr_data(s_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule
